// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the memory access stage.
// Sub-word lanes assume a 32-bit word built from four byte lanes.
package mem_stage_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;
    localparam int unsigned WORD_W = BYTE_W * LANES;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'd0,
        FWD_WB   = 2'd1,
        FWD_LOAD = 2'd2,
        FWD_ZERO = 2'd3
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reserved size behaves as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (mem_size_e'(size))
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = off[0];
            default:   is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [LANES-1:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        case (mem_size_e'(size))
            SIZE_BYTE: byte_enable = 4'b0001 << off;
            SIZE_HALF: byte_enable = 4'b0011 << off;
            default:   byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        size,
                                                      input logic [1:0]        off,
                                                      input logic              uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (mem_size_e'(size))
            SIZE_BYTE: load_extend = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SIZE_HALF: load_extend = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default:   load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/be_sync_ram.sv
// Single-port byte-lane RAM with registered read; read-during-write returns old data.
module be_sync_ram
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  en_i,
    input  logic [LANES-1:0]      we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (en_i) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][i*BYTE_W +: BYTE_W] <= wdata_i[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: lane steering, store forwarding, wait-state FSM and
// registered results towards writeback.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] writedata2,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [1:0]            mem_size,
    input  logic                  mem_unsigned,
    input  logic [1:0]            forward_sel,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned_out
);

    localparam int unsigned      CNT_W    = 3;
    localparam bit               HAS_WAIT = (WAIT_STATES != 0);
    localparam logic [CNT_W-1:0] CNT_INIT = HAS_WAIT ? CNT_W'(WAIT_STATES - 1) : '0;

    logic [1:0]            off_c;
    logic [ADDR_WIDTH-1:0] widx_c;
    logic                  is_mem_c;
    logic                  is_load_c;
    logic                  mis_c;
    logic                  access_c;
    logic [DATA_WIDTH-1:0] st_src_c;
    logic [DATA_WIDTH-1:0] st_data_c;
    logic [LANES-1:0]      be_c;
    logic                  commit_c;
    logic                  pass_c;
    logic                  ram_en_c;
    logic [LANES-1:0]      ram_we_c;
    logic [DATA_WIDTH-1:0] ram_rdata;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  ld_q, ld_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [1:0]            size_q, size_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [DATA_WIDTH-1:0] last_load_q;

    assign off_c     = alu_result[1:0];
    assign widx_c    = alu_result[ADDR_WIDTH+1:2];
    assign is_mem_c  = mem_read | mem_write;
    assign is_load_c = mem_read & ~mem_write;
    assign mis_c     = is_mem_c & is_misaligned(mem_size, off_c);
    assign access_c  = valid_in & is_mem_c & ~mis_c;
    assign be_c      = byte_enable(mem_size, off_c);

    // Store-data source and lane replication.
    always_comb begin
        case (fwd_sel_e'(forward_sel))
            FWD_RF:   st_src_c = write_data;
            FWD_WB:   st_src_c = writedata2;
            FWD_LOAD: st_src_c = last_load_q;
            default:  st_src_c = '0;
        endcase
        case (mem_size_e'(mem_size))
            SIZE_BYTE: st_data_c = {4{st_src_c[7:0]}};
            SIZE_HALF: st_data_c = {2{st_src_c[15:0]}};
            default:   st_data_c = st_src_c;
        endcase
    end

    // An aligned access arriving in DONE is held and replayed from IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_out = 1'b0;
        commit_c  = 1'b0;
        pass_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_in) begin
                    if (!access_c) begin
                        pass_c = 1'b1;
                    end else if (!HAS_WAIT) begin
                        commit_c = 1'b1;
                    end else begin
                        stall_out = 1'b1;
                        state_d   = ST_WAIT;
                        cnt_d     = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    stall_out = 1'b1;
                    cnt_d     = cnt_q - CNT_W'(1);
                end else begin
                    commit_c = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (valid_in) begin
                    if (access_c) stall_out = 1'b1;
                    else          pass_c    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d  = 1'b0;
        mis_d    = 1'b0;
        ld_d     = 1'b0;
        alu_d    = alu_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        ram_en_c = 1'b0;
        ram_we_c = '0;
        if (commit_c) begin
            ram_en_c = 1'b1;
            ram_we_c = mem_write ? be_c : '0;
            valid_d  = 1'b1;
            ld_d     = is_load_c;
            alu_d    = alu_result;
            off_d    = off_c;
            size_d   = mem_size;
            uns_d    = mem_unsigned;
        end else if (pass_c) begin
            valid_d = 1'b1;
            mis_d   = mis_c;
            alu_d   = alu_result;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            mis_q       <= 1'b0;
            ld_q        <= 1'b0;
            uns_q       <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            alu_q       <= '0;
            last_load_q <= '0;
        end else begin
            valid_q <= valid_d;
            mis_q   <= mis_d;
            ld_q    <= ld_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            size_q  <= size_d;
            alu_q   <= alu_d;
            if (valid_q && ld_q) begin
                last_load_q <= load_data;
            end
        end
    end

    be_sync_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clock  (clock),
        .reset_n(reset_n),
        .en_i   (ram_en_c),
        .we_i   (ram_we_c),
        .addr_i (widx_c),
        .wdata_i(st_data_c),
        .rdata_o(ram_rdata)
    );

    // Lane extraction works off the registered read word and captured lane info.
    assign load_data      = ld_q ? load_extend(ram_rdata, size_q, off_q, uns_q) : '0;
    assign valid_out      = valid_q;
    assign misaligned_out = mis_q;
    assign alu_result_out = alu_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench: one stage with no wait states and one with three, sharing data inputs.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;
    localparam logic [1:0] SR = 2'b11;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        v0, v3;
    logic [31:0] alu, wd, wd2;
    logic        rd, wr, uns;
    logic [1:0]  size, fsel;

    logic        stall0, valid0, mis0, stall3, valid3, mis3;
    logic [31:0] alu0, load0, alu3, load3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (
        .clock(clock), .reset_n(reset_n), .valid_in(v0), .alu_result(alu),
        .write_data(wd), .writedata2(wd2), .mem_read(rd), .mem_write(wr),
        .mem_size(size), .mem_unsigned(uns), .forward_sel(fsel),
        .stall_out(stall0), .valid_out(valid0), .alu_result_out(alu0),
        .load_data(load0), .misaligned_out(mis0)
    );

    mem_access_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (
        .clock(clock), .reset_n(reset_n), .valid_in(v3), .alu_result(alu),
        .write_data(wd), .writedata2(wd2), .mem_read(rd), .mem_write(wr),
        .mem_size(size), .mem_unsigned(uns), .forward_sel(fsel),
        .stall_out(stall3), .valid_out(valid3), .alu_result_out(alu3),
        .load_data(load3), .misaligned_out(mis3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                         input logic [1:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] d2);
        rd = r; wr = w; size = s; uns = u; fsel = f; alu = a; wd = d; wd2 = d2;
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    // Zero-wait stage: result one cycle after issue, never stalls.
    task automatic op0(input string tag, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] d2,
                       input logic em, input logic [31:0] el);
        drive(r, w, s, u, f, a, d, d2);
        v0 = 1'b1;
        @(negedge clock);
        check({tag, ".stall"}, 32'(stall0), 32'(0));
        @(posedge clock);
        #1;
        v0 = 1'b0;
        check({tag, ".valid"}, 32'(valid0), 32'(1));
        check({tag, ".mis"},   32'(mis0),   32'(em));
        check({tag, ".load"},  load0,       el);
        check({tag, ".alu"},   alu0,        a);
    endtask

    // Three-wait stage: aligned access stalls 3 cycles, result 4 cycles after issue.
    task automatic op3(input string tag, input logic r, input logic w, input logic [1:0] s,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic em, input logic [31:0] el);
        int lat;
        idle();
        lat = em ? 1 : 4;
        drive(r, w, s, u, 2'd0, a, d, 32'h0);
        v3 = 1'b1;
        for (int c = 0; c < lat; c++) begin
            @(negedge clock);
            check($sformatf("%s.stall%0d", tag, c), 32'(stall3), 32'(c < lat - 1));
            check($sformatf("%s.early%0d", tag, c), 32'(valid3), 32'(0));
            @(posedge clock);
            #1;
        end
        v3 = 1'b0;
        check({tag, ".valid"}, 32'(valid3), 32'(1));
        check({tag, ".mis"},   32'(mis3),   32'(em));
        check({tag, ".load"},  load3,       el);
        check({tag, ".alu"},   alu3,        a);
    endtask

    initial begin
        reset_n = 1'b0;
        v0 = 1'b0;
        v3 = 1'b0;
        drive(1'b0, 1'b0, SW, 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
        #12;
        check("rst.valid0", 32'(valid0), 32'(0));
        check("rst.mis0",   32'(mis0),   32'(0));
        check("rst.alu0",   alu0,        32'h0);
        check("rst.load0",  load0,       32'h0);
        check("rst.stall0", 32'(stall0), 32'(0));
        check("rst.valid3", 32'(valid3), 32'(0));
        check("rst.load3",  load3,       32'h0);
        check("rst.stall3", 32'(stall3), 32'(0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        //            tag     rd    wr    sz  u     f     addr          wd            wd2           mis   load
        op0("stw10",  1'b0, 1'b1, SW, 1'b0, 2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'h0);
        op0("ldw10",  1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 32'hDEAD_BEEF);
        op0("stb13",  1'b0, 1'b1, SB, 1'b0, 2'd0, 32'h0000_0013, 32'h0000_00A5, 32'h0,       1'b0, 32'h0);
        op0("ldbs13", 1'b1, 1'b0, SB, 1'b0, 2'd0, 32'h0000_0013, 32'h0,        32'h0,        1'b0, 32'hFFFF_FFA5);
        op0("ldbu13", 1'b1, 1'b0, SB, 1'b1, 2'd0, 32'h0000_0013, 32'h0,        32'h0,        1'b0, 32'h0000_00A5);
        op0("ldw10b", 1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 32'hA5AD_BEEF);
        op0("ldh11",  1'b1, 1'b0, SH, 1'b0, 2'd0, 32'h0000_0011, 32'h0,        32'h0,        1'b1, 32'h0);
        op0("sth11",  1'b0, 1'b1, SH, 1'b0, 2'd0, 32'h0000_0011, 32'h0000_1234, 32'h0,       1'b1, 32'h0);
        idle();
        check("gap.valid0", 32'(valid0), 32'(0));
        check("gap.mis0",   32'(mis0),   32'(0));
        op0("ldw10c", 1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 32'hA5AD_BEEF);
        op0("stw13",  1'b0, 1'b1, SW, 1'b0, 2'd0, 32'h0000_0013, 32'h5555_5555, 32'h0,       1'b1, 32'h0);
        op0("sth12",  1'b0, 1'b1, SH, 1'b0, 2'd0, 32'h0000_0012, 32'hFFFF_7E81, 32'h0,       1'b0, 32'h0);
        op0("ldhs12", 1'b1, 1'b0, SH, 1'b0, 2'd0, 32'h0000_0012, 32'h0,        32'h0,        1'b0, 32'h0000_7E81);
        op0("ldbs12", 1'b1, 1'b0, SB, 1'b0, 2'd0, 32'h0000_0012, 32'h0,        32'h0,        1'b0, 32'hFFFF_FF81);
        op0("ldhu10", 1'b1, 1'b0, SH, 1'b1, 2'd0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 32'h0000_BEEF);
        op0("ldhs10", 1'b1, 1'b0, SH, 1'b0, 2'd0, 32'h0000_0010, 32'h0,        32'h0,        1'b0, 32'hFFFF_BEEF);
        op0("ldwhi",  1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_1010, 32'h0,        32'h0,        1'b0, 32'h7E81_BEEF);
        op0("alu",    1'b0, 1'b0, SH, 1'b0, 2'd0, 32'hCAFE_0003, 32'h0,        32'h0,        1'b0, 32'h0);
        op0("rdwr20", 1'b1, 1'b1, SW, 1'b0, 2'd0, 32'h0000_0020, 32'h1122_3344, 32'h0,       1'b0, 32'h0);
        op0("ldw20",  1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0020, 32'h0,        32'h0,        1'b0, 32'h1122_3344);
        op0("stw30",  1'b0, 1'b1, SW, 1'b0, 2'd0, 32'h0000_0030, 32'h1234_5678, 32'h0,       1'b0, 32'h0);
        op0("ldw30",  1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0030, 32'h0,        32'h0,        1'b0, 32'h1234_5678);
        idle();
        op0("fwd2st", 1'b0, 1'b1, SW, 1'b0, 2'd2, 32'h0000_0034, 32'hFFFF_FFFF, 32'h0,       1'b0, 32'h0);
        op0("fwd2ld", 1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0034, 32'h0,        32'h0,        1'b0, 32'h1234_5678);
        op0("fwd3st", 1'b0, 1'b1, SW, 1'b0, 2'd3, 32'h0000_0038, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0);
        op0("fwd3ld", 1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_0038, 32'h0,        32'h0,        1'b0, 32'h0);
        op0("fwd1st", 1'b0, 1'b1, SW, 1'b0, 2'd1, 32'h0000_003C, 32'h0000_0001, 32'h0BAD_F00D, 1'b0, 32'h0);
        op0("fwd1ld", 1'b1, 1'b0, SW, 1'b0, 2'd0, 32'h0000_003C, 32'h0,        32'h0,        1'b0, 32'h0BAD_F00D);
        op0("rsv30",  1'b1, 1'b0, SR, 1'b0, 2'd0, 32'h0000_0030, 32'h0,        32'h0,        1'b0, 32'h1234_5678);
        op0("rsv32",  1'b1, 1'b0, SR, 1'b0, 2'd0, 32'h0000_0032, 32'h0,        32'h0,        1'b1, 32'h0);

        //           tag      rd    wr    sz  u     addr           wd             mis   load
        op3("w3stw", 1'b0, 1'b1, SW, 1'b0, 32'h0000_0040, 32'hCAFE_BABE, 1'b0, 32'h0);
        op3("w3ldw", 1'b1, 1'b0, SW, 1'b0, 32'h0000_0040, 32'h0,         1'b0, 32'hCAFE_BABE);
        op3("w3mis", 1'b1, 1'b0, SW, 1'b0, 32'h0000_0042, 32'h0,         1'b1, 32'h0);
        op3("w3ldb", 1'b1, 1'b0, SB, 1'b1, 32'h0000_0041, 32'h0,         1'b0, 32'h0000_00BA);

        // Abort a store while it is still waiting.
        idle();
        drive(1'b0, 1'b1, SW, 1'b0, 2'd0, 32'h0000_0040, 32'h1111_1111, 32'h0);
        v3 = 1'b1;
        idle();
        idle();
        check("abort.stall_pre", 32'(stall3), 32'(1));
        reset_n = 1'b0;
        v3 = 1'b0;
        #1;
        check("abort.valid", 32'(valid3), 32'(0));
        check("abort.mis",   32'(mis3),   32'(0));
        check("abort.alu",   alu3,        32'h0);
        check("abort.load",  load3,       32'h0);
        check("abort.stall", 32'(stall3), 32'(0));
        check("abort.fsm",   32'(u_ws3.state_q), 32'(ST_IDLE));
        check("abort.cnt",   32'(u_ws3.cnt_q),   32'(0));
        idle();
        reset_n = 1'b1;
        idle();
        check("abort.fsm_post", 32'(u_ws3.state_q), 32'(ST_IDLE));
        op3("w3rerd", 1'b1, 1'b0, SW, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 32'hCAFE_BABE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
